// File: rtl/regfile_scoreboard_if.sv
// Port bundle for regfile_scoreboard: two read ports, one write port,
// one reserve port and the busy count.
interface regfile_scoreboard_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ReadRegister1;
    logic [ADDR_W-1:0] ReadRegister2;
    logic [WIDTH-1:0]  ReadData1;
    logic [WIDTH-1:0]  ReadData2;
    logic              ReadReady1;
    logic              ReadReady2;
    logic [ADDR_W-1:0] WriteRegister;
    logic [WIDTH-1:0]  WriteData;
    logic              RegWrite;
    logic [ADDR_W-1:0] ReserveRegister;
    logic              Reserve;
    logic [ADDR_W:0]   BusyCount;

    modport master (
        output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
               ReserveRegister, Reserve,
        input  ReadData1, ReadData2, ReadReady1, ReadReady2, BusyCount
    );

    modport slave (
        input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
               ReserveRegister, Reserve,
        output ReadData1, ReadData2, ReadReady1, ReadReady2, BusyCount
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with a busy-bit scoreboard for RAW stalls and optional
// same-cycle write-to-read bypass. Register 0 always reads as zero.
module regfile_scoreboard #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input logic                 Clk,
    input logic                 Reset,
    regfile_scoreboard_if.slave bus
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            busy;
    logic [DEPTH-1:0]            busy_next;
    logic [DEPTH-1:0]            wr_mask;
    logic [DEPTH-1:0]            rsv_mask;
    logic [ADDR_W:0]             busy_count;
    logic [ADDR_W:0]             count_next;
    logic                        set_new;
    logic                        clr_old;
    logic [WIDTH:0]              rd1;
    logic [WIDTH:0]              rd2;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a != '0) && ({1'b0, a} < DEPTH_L);
    endfunction

    function automatic logic [DEPTH-1:0] decode(input logic en, input logic [ADDR_W-1:0] a);
        logic [DEPTH-1:0] m;
        m = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (en && (a == ADDR_W'(i))) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Returns {ready, data}; an equal write address is already known in range.
    function automatic logic [WIDTH:0] read_port(
        input logic [ADDR_W-1:0]            a,
        input logic [DEPTH-1:0][WIDTH-1:0]  r,
        input logic [DEPTH-1:0]             b,
        input logic                         wr_en,
        input logic [ADDR_W-1:0]            wa,
        input logic [WIDTH-1:0]             wd
    );
        logic [WIDTH:0] res;
        res = {1'b1, {WIDTH{1'b0}}};
        if (in_range(a)) begin
            if ((BYPASS != 0) && wr_en && (wa == a)) begin
                res = {1'b1, wd};
            end else begin
                for (int i = 1; i < DEPTH; i++) begin
                    if (a == ADDR_W'(i)) res = {~b[i], r[i]};
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        wr_mask  = decode(bus.RegWrite && in_range(bus.WriteRegister), bus.WriteRegister);
        rsv_mask = decode(bus.Reserve && in_range(bus.ReserveRegister), bus.ReserveRegister);
        // Reserve is applied after the write clear, so it wins on the same register.
        busy_next  = (busy & ~wr_mask) | rsv_mask;
        set_new    = |(rsv_mask & ~busy);
        clr_old    = |(wr_mask & busy & ~rsv_mask);
        count_next = busy_count + {{ADDR_W{1'b0}}, set_new} - {{ADDR_W{1'b0}}, clr_old};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            regs <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_mask[i]) regs[i] <= bus.WriteData;
            end
        end
    end

    always_comb begin
        rd1 = read_port(bus.ReadRegister1, regs, busy, bus.RegWrite, bus.WriteRegister, bus.WriteData);
        rd2 = read_port(bus.ReadRegister2, regs, busy, bus.RegWrite, bus.WriteRegister, bus.WriteData);
    end

    assign bus.ReadData1  = rd1[WIDTH-1:0];
    assign bus.ReadReady1 = rd1[WIDTH];
    assign bus.ReadData2  = rd2[WIDTH-1:0];
    assign bus.ReadReady2 = rd2[WIDTH];
    assign bus.BusyCount  = busy_count;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: three instances (bypass, no bypass, 16x20)
// driven by shared stimulus and compared against an array-based model.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic        we;
    logic        rsv;
    logic [4:0]  wreg;
    logic [4:0]  rsvreg;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [31:0] wdata;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_scoreboard_if #(.WIDTH(32), .ADDR_W(5)) if_a ();
    regfile_scoreboard_if #(.WIDTH(32), .ADDR_W(5)) if_b ();
    regfile_scoreboard_if #(.WIDTH(16), .ADDR_W(5)) if_c ();

    assign if_a.ReadRegister1 = rr1;     assign if_b.ReadRegister1 = rr1;     assign if_c.ReadRegister1 = rr1;
    assign if_a.ReadRegister2 = rr2;     assign if_b.ReadRegister2 = rr2;     assign if_c.ReadRegister2 = rr2;
    assign if_a.WriteRegister = wreg;    assign if_b.WriteRegister = wreg;    assign if_c.WriteRegister = wreg;
    assign if_a.WriteData     = wdata;   assign if_b.WriteData     = wdata;   assign if_c.WriteData     = wdata[15:0];
    assign if_a.RegWrite      = we;      assign if_b.RegWrite      = we;      assign if_c.RegWrite      = we;
    assign if_a.ReserveRegister = rsvreg; assign if_b.ReserveRegister = rsvreg; assign if_c.ReserveRegister = rsvreg;
    assign if_a.Reserve       = rsv;     assign if_b.Reserve       = rsv;     assign if_c.Reserve       = rsv;

    regfile_scoreboard #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .BYPASS(1)) u_a (.Clk(clk), .Reset(rst), .bus(if_a));
    regfile_scoreboard #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .BYPASS(0)) u_b (.Clk(clk), .Reset(rst), .bus(if_b));
    regfile_scoreboard #(.WIDTH(16), .DEPTH(20), .ADDR_W(5), .BYPASS(1)) u_c (.Clk(clk), .Reset(rst), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain register and busy arrays per instance.
    int          m_depth  [3] = '{32, 32, 20};
    bit          m_bypass [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] m_mask   [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
    logic [31:0] m_val    [3][32];
    bit          m_busy   [3][32];

    function automatic bit valid_addr(input int k, input logic [4:0] a);
        return (a != 5'd0) && (int'(a) < m_depth[k]);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 32; i++) begin
                m_val[k][i]  = 32'h0;
                m_busy[k][i] = 1'b0;
            end
    endfunction

    function automatic void model_step();
        for (int k = 0; k < 3; k++) begin
            if (we && valid_addr(k, wreg)) begin
                m_val[k][wreg]  = wdata & m_mask[k];
                m_busy[k][wreg] = 1'b0;
            end
            if (rsv && valid_addr(k, rsvreg)) m_busy[k][rsvreg] = 1'b1;
        end
    endfunction

    function automatic void exp_read(input int k, input logic [4:0] a, output logic [31:0] d, output logic r);
        if (!valid_addr(k, a)) begin
            d = 32'h0; r = 1'b1;
        end else if (m_bypass[k] && we && (wreg == a)) begin
            d = wdata & m_mask[k]; r = 1'b1;
        end else begin
            d = m_val[k][a]; r = !m_busy[k][a];
        end
    endfunction

    function automatic int exp_count(input int k);
        int c = 0;
        for (int i = 0; i < 32; i++) if (m_busy[k][i]) c++;
        return c;
    endfunction

    // sel: 0 ReadData1, 1 ReadReady1, 2 ReadData2, 3 ReadReady2, 4 BusyCount
    function automatic logic [31:0] act(input int k, input int sel);
        logic [31:0] v = 32'h0;
        case (k)
            0: case (sel)
                   0: v = if_a.ReadData1;
                   1: v = {31'h0, if_a.ReadReady1};
                   2: v = if_a.ReadData2;
                   3: v = {31'h0, if_a.ReadReady2};
                   default: v = {26'h0, if_a.BusyCount};
               endcase
            1: case (sel)
                   0: v = if_b.ReadData1;
                   1: v = {31'h0, if_b.ReadReady1};
                   2: v = if_b.ReadData2;
                   3: v = {31'h0, if_b.ReadReady2};
                   default: v = {26'h0, if_b.BusyCount};
               endcase
            default: case (sel)
                   0: v = {16'h0, if_c.ReadData1};
                   1: v = {31'h0, if_c.ReadReady1};
                   2: v = {16'h0, if_c.ReadData2};
                   3: v = {31'h0, if_c.ReadReady2};
                   default: v = {26'h0, if_c.BusyCount};
               endcase
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_model();
        logic [31:0] d;
        logic        r;
        for (int k = 0; k < 3; k++) begin
            exp_read(k, rr1, d, r);
            chk($sformatf("dut%0d data1 r%0d", k, rr1), act(k, 0), d);
            chk($sformatf("dut%0d ready1 r%0d", k, rr1), act(k, 1), {31'h0, r});
            exp_read(k, rr2, d, r);
            chk($sformatf("dut%0d data2 r%0d", k, rr2), act(k, 2), d);
            chk($sformatf("dut%0d ready2 r%0d", k, rr2), act(k, 3), {31'h0, r});
            chk($sformatf("dut%0d busy_count", k), act(k, 4), 32'(exp_count(k)));
        end
    endtask

    task automatic set_in(input logic we_i, input logic [4:0] wreg_i, input logic [31:0] wdata_i,
                          input logic rsv_i, input logic [4:0] rsvreg_i,
                          input logic [4:0] rr1_i, input logic [4:0] rr2_i);
        we = we_i; wreg = wreg_i; wdata = wdata_i;
        rsv = rsv_i; rsvreg = rsvreg_i;
        rr1 = rr1_i; rr2 = rr2_i;
    endtask

    task automatic pre_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic post_edge();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        rsv;
        logic [4:0]  rsvreg;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [31:0] d1;
        logic        r1;
        logic [31:0] d2;
        logic        r2;
        int          cnt;
    } vec_t;

    vec_t vecs [18];

    initial begin
        // we wreg wdata rsv rsvreg rr1 rr2 | d1 r1 d2 r2 count-after-edge (bypassing instance)
        vecs[0]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 5'd31, 32'h0,         1'b1, 32'h0,         1'b1, 0};
        vecs[1]  = '{1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 5'd7, 5'd7,  32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd7, 5'd7,  32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 0};
        vecs[3]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, 5'd7,  32'h0,         1'b1, 32'h1234_5678, 1'b1, 0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 5'd0,  32'h0,         1'b1, 32'h0,         1'b1, 0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 5'd3, 5'd3,  32'h0,         1'b1, 32'h0,         1'b1, 1};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 5'd3, 5'd3,  32'h0,         1'b0, 32'h0,         1'b0, 1};
        vecs[7]  = '{1'b1, 5'd3, 32'hA5A5_A5A5, 1'b0, 5'd0, 5'd3, 5'd3,  32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 1'b1, 0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd3, 5'd3,  32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 1'b1, 0};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 5'd9, 5'd9,  32'h0,         1'b1, 32'h0,         1'b1, 1};
        vecs[10] = '{1'b1, 5'd9, 32'hCAFE_F00D, 1'b0, 5'd0, 5'd9, 5'd9,  32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b1, 0};
        vecs[11] = '{1'b1, 5'd4, 32'h11,        1'b1, 5'd4, 5'd4, 5'd4,  32'h11,        1'b1, 32'h11,        1'b1, 1};
        vecs[12] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd4, 5'd4,  32'h11,        1'b0, 32'h11,        1'b0, 1};
        vecs[13] = '{1'b1, 5'd4, 32'h22,        1'b1, 5'd6, 5'd6, 5'd4,  32'h0,         1'b1, 32'h22,        1'b1, 1};
        vecs[14] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd4, 5'd6,  32'h22,        1'b1, 32'h0,         1'b0, 1};
        vecs[15] = '{1'b1, 5'd6, 32'h5,         1'b1, 5'd6, 5'd6, 5'd6,  32'h5,         1'b1, 32'h5,         1'b1, 1};
        vecs[16] = '{1'b1, 5'd6, 32'h66,        1'b0, 5'd0, 5'd6, 5'd3,  32'h66,        1'b1, 32'hA5A5_A5A5, 1'b1, 0};
        vecs[17] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd6, 5'd9,  32'h66,        1'b1, 32'hCAFE_F00D, 1'b1, 0};

        rst = 1'b1;
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        // Reset state: every address reads zero and ready
        for (int a = 0; a < 32; a++) begin
            set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(a), 5'(31 - a));
            pre_edge();
            post_edge();
        end

        for (int i = 0; i < 18; i++) begin
            set_in(vecs[i].we, vecs[i].wreg, vecs[i].wdata, vecs[i].rsv, vecs[i].rsvreg, vecs[i].rr1, vecs[i].rr2);
            pre_edge();
            chk($sformatf("vec%0d data1", i),  if_a.ReadData1, vecs[i].d1);
            chk($sformatf("vec%0d ready1", i), {31'h0, if_a.ReadReady1}, {31'h0, vecs[i].r1});
            chk($sformatf("vec%0d data2", i),  if_a.ReadData2, vecs[i].d2);
            chk($sformatf("vec%0d ready2", i), {31'h0, if_a.ReadReady2}, {31'h0, vecs[i].r2});
            post_edge();
            chk($sformatf("vec%0d count", i),  {26'h0, if_a.BusyCount}, 32'(vecs[i].cnt));
        end

        // Asynchronous reset between edges discards data and reservations at once
        set_in(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd8, 5'd5, 5'd8);
        pre_edge();
        post_edge();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd8);
        #1;
        chk("pre-reset r5 data", if_a.ReadData1, 32'hDEAD_BEEF);
        chk("pre-reset r8 ready", {31'h0, if_a.ReadReady2}, 32'h0);
        rst = 1'b1;
        #1;
        model_reset();
        chk("async reset r5 data", if_a.ReadData1, 32'h0);
        chk("async reset r5 ready", {31'h0, if_a.ReadReady1}, 32'h1);
        chk("async reset r8 ready", {31'h0, if_a.ReadReady2}, 32'h1);
        chk("async reset count", {26'h0, if_a.BusyCount}, 32'h0);
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd8);
        @(posedge clk);
        #1;
        chk("held reset ready", {31'h0, if_a.ReadReady1}, 32'h1);
        chk("held reset count", {26'h0, if_a.BusyCount}, 32'h0);
        rst = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd8);
        pre_edge();
        post_edge();

        // Bypass versus no bypass on a busy register
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd10, 5'd10);
        pre_edge();
        post_edge();
        set_in(1'b1, 5'd10, 32'hCAFE_F00D, 1'b0, 5'd0, 5'd10, 5'd10);
        pre_edge();
        chk("bypass data", if_a.ReadData1, 32'hCAFE_F00D);
        chk("bypass ready", {31'h0, if_a.ReadReady1}, 32'h1);
        chk("nobypass old data", if_b.ReadData1, 32'h0);
        chk("nobypass ready", {31'h0, if_b.ReadReady1}, 32'h0);
        post_edge();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd10);
        pre_edge();
        chk("nobypass next data", if_b.ReadData1, 32'hCAFE_F00D);
        chk("nobypass next ready", {31'h0, if_b.ReadReady1}, 32'h1);
        post_edge();

        // Narrow, shallow instance: top register works, r25 is out of range
        set_in(1'b1, 5'd19, 32'h1234_BEEF, 1'b0, 5'd0, 5'd19, 5'd0);
        pre_edge();
        chk("c r19 bypass", {16'h0, if_c.ReadData1}, 32'h0000_BEEF);
        post_edge();
        set_in(1'b1, 5'd25, 32'h1234, 1'b1, 5'd25, 5'd25, 5'd19);
        pre_edge();
        chk("c r25 data", {16'h0, if_c.ReadData1}, 32'h0);
        chk("c r25 ready", {31'h0, if_c.ReadReady1}, 32'h1);
        chk("c r19 data", {16'h0, if_c.ReadData2}, 32'h0000_BEEF);
        post_edge();
        chk("c r25 count", {26'h0, if_c.BusyCount}, 32'h0);
        chk("a r25 count", {26'h0, if_a.BusyCount}, 32'h1);
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd25, 5'd19);
        pre_edge();
        chk("c r25 after", {16'h0, if_c.ReadData1}, 32'h0);
        post_edge();

        // Randomised traffic with collisions biased in
        for (int i = 0; i < 600; i++) begin
            we     = 1'($urandom_range(0, 1));
            wreg   = 5'($urandom_range(0, 31));
            wdata  = $urandom;
            rsv    = ($urandom_range(0, 2) == 0);
            rsvreg = ($urandom_range(0, 3) == 0) ? wreg : 5'($urandom_range(0, 31));
            rr1    = ($urandom_range(0, 3) == 0) ? wreg : 5'($urandom_range(0, 31));
            rr2    = ($urandom_range(0, 3) == 0) ? rsvreg : 5'($urandom_range(0, 31));
            if (i == 300) begin
                #1 rst = 1'b1;
                #1;
                model_reset();
                check_model();
                @(posedge clk);
                #1 rst = 1'b0;
            end else begin
                pre_edge();
                post_edge();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised register file with an integrated busy-bit scoreboard and optional write-to-read bypass. It is the next-generation register file for the MIPS datapath and supports configurable width and depth. It tracks in-flight producers so the issue stage can stall on RAW hazards, and it forwards same-cycle write data to the read ports. Register 0 is a hard zero.

Parameters:
WIDTH, 32, data bits per register
DEPTH, 32, number of registers (2..2^ADDR_W)
ADDR_W, 5, register address width
BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports; 0 = reads see stored contents only

Ports:
Clk  input  1  clock, all state updates on posedge
Reset  input  1  asynchronous, active-high reset
ReadRegister1  input  ADDR_W  read port 1 address
ReadRegister2  input  ADDR_W  read port 2 address
ReadData1  output  WIDTH  read port 1 data (combinational)
ReadData2  output  WIDTH  read port 2 data (combinational)
ReadReady1  output  1  high when ReadData1 is valid (no pending producer)
ReadReady2  output  1  high when ReadData2 is valid
WriteRegister  input  ADDR_W  write address
WriteData  input  WIDTH  write data
RegWrite  input  1  write enable
ReserveRegister  input  ADDR_W  register claimed by a newly issued producer
Reserve  input  1  sets the busy bit of ReserveRegister
BusyCount  output  ADDR_W+1  registered count of set busy bits

Behaviour:
- Reset (async, active-high): all registers go to 0, all busy bits go to 0, BusyCount goes to 0, and the state holds while Reset is high. A Reset asserted mid-operation discards pending reservations immediately.
- Write: on posedge Clk with RegWrite=1 and 0 < WriteRegister < DEPTH, the register loads WriteData and its busy bit clears. Writes to register 0 or to an address >= DEPTH are ignored.
- Reserve: on posedge Clk with Reserve=1 and 0 < ReserveRegister < DEPTH, the busy bit sets. Reserving a register that is already busy leaves it busy (WAW allowed; the count is unchanged). Reserves of register 0 or of an out-of-range address are ignored.
- Same-cycle write and reserve:
  - Same register: the reserve wins, the data is stored, and the busy bit stays or becomes 1.
  - Different registers: both take effect.
- BusyCount equals the number of set busy bits after the edge; it is updated in the same edge as the busy bits, with a net change of -1, 0 or +1 per cycle.
- Read port N (combinational), evaluated in this order:
  - Address 0 or >= DEPTH: data 0, ready 1.
  - BYPASS=1, RegWrite=1 and WriteRegister == ReadRegisterN (nonzero, in range): data = WriteData, ready 1. The bypass ignores a same-cycle reserve of that register; the reserve only affects later cycles.
  - Otherwise: data = stored value, ready = ~busy bit.
- With BYPASS=0, a same-cycle write is visible only from the next cycle, and ready follows the busy bit as it stands before the edge.
- Both read ports are independent and may address the same register.
- No width extension or truncation: WriteData is stored verbatim, WIDTH bits.

Test Plan:
- Reset check: after Reset pulse → both ReadData = 0, ReadReady = 1 for all addresses, BusyCount = 0. Then assert Reset asynchronously between edges after a write of 0xDEADBEEF to r5 → ReadData1(r5) = 0 immediately.
- Write/read: write 0x12345678 to r7; next cycle read r7 on both ports → 0x12345678, ready 1. Write 0xFFFFFFFF to r0 → r0 still reads 0.
- Scoreboard: reserve r3 → next cycle ReadReady1(r3) = 0, BusyCount = 1. Reserve r3 again → BusyCount stays 1. Write 0xA5A5A5A5 to r3 → ready 1, BusyCount = 0.
- Bypass (BYPASS=1): r9 busy; in one cycle RegWrite r9 = 0xCAFEF00D while reading r9 → ReadData1 = 0xCAFEF00D, ReadReady1 = 1 in that same cycle. Repeat with BYPASS=0 → old value returned and ready 0 until after the edge.
- Collisions:
  - Same cycle, write r4 = 0x11 and reserve r4 → r4 stores 0x11, busy stays 1, BusyCount +1.
  - Same cycle, write r4 and reserve r6 (r4 previously busy) → BusyCount unchanged net.
- Parameter sweep: WIDTH=16, DEPTH=20 → write 0xBEEF to r19 reads back 0xBEEF. Write or reserve r25 is ignored; reading r25 returns 0 with ready 1.
